// File: rtl/vec_player.sv
// vec_player: on-chip vector replay. Each stored vector's stimulus field is
// driven to a downstream DUT. The DUT response is sampled LAT cycles later
// and compared with the vector's expected-response field. The block counts
// mismatches and reports pass/fail when the run finishes.
module vec_player #(
  parameter int STIM_W = 15,
  parameter int RESP_W = 10,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4,
  parameter int LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [STIM_W+RESP_W-1:0] ld_data,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_vec,
  input  logic [RESP_W-1:0]        dut_resp,
  output logic [STIM_W-1:0]        stim_out,
  output logic                     stim_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     mismatch,
  output logic [ADDR_W-1:0]        vec_idx,
  output logic [15:0]              err_cnt,
  output logic [ADDR_W-1:0]        first_err_idx
);

  localparam int VEC_W = STIM_W + RESP_W;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LAT > 1) ? (LAT - 2) : 0);
  localparam logic [ADDR_W:0]  DEPTH_N   = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [VEC_W-1:0]  mem [DEPTH];
  logic [2:0]        state;
  logic [ADDR_W:0]   n_run;
  logic [CNT_W-1:0]  wait_cnt;
  logic              idle;
  logic              accept;
  logic              resp_ok;
  logic              last;
  logic [VEC_W-1:0]  cur_vec;
  logic [ADDR_W:0]   n_clamp;

  assign idle       = (state == S_IDLE) || (state == S_DONE);
  assign accept     = idle && start && (num_vec != '0);
  assign n_clamp    = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign cur_vec    = mem[vec_idx];
  assign resp_ok    = (dut_resp == cur_vec[RESP_W-1:0]);
  assign last       = ({1'b0, vec_idx} == (n_run - 1'b1));

  assign busy       = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign stim_valid = (state == S_DRIVE);
  assign mismatch   = (state == S_CHECK) && !resp_ok;

  // Vector memory write port; only open while no run is in progress, never cleared.
  always_ff @(posedge clk) begin
    if (ld_en && idle && ({1'b0, ld_addr} < DEPTH_N)) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Run sequencer: drive, wait out the DUT latency, check, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      n_run         <= '0;
      wait_cnt      <= '0;
      stim_out      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_idx       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            n_run         <= n_clamp;
            err_cnt       <= '0;
            first_err_idx <= '0;
            vec_idx       <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            state         <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          stim_out <= cur_vec[VEC_W-1:RESP_W];
          wait_cnt <= '0;
          state    <= (LAT > 1) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (!resp_ok) begin
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 16'd1;
            end
            // err_cnt never wraps back to zero, so zero marks "no error yet this run".
            if (err_cnt == '0) begin
              first_err_idx <= vec_idx;
            end
          end
          if (last) begin
            done  <= 1'b1;
            pass  <= resp_ok && (err_cnt == '0);
            state <= S_DONE;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            state   <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_player.sv
// tb_vec_player: two vec_player instances (LAT=1 and LAT=3) share all inputs.
// A reference model of the vector memory turns every accepted start into
// per-vector and per-run expectations in queues. One monitor per instance
// pops and checks those expectations when the instance drives a vector
// and when it raises done.
module tb_vec_player;

  localparam int SW = 15;
  localparam int RW = 10;
  localparam int DEP = 10;
  localparam int AW = 4;

  typedef struct {
    int           idx;
    logic [SW-1:0] stim;
    logic          bad;
  } vec_t;

  typedef struct {
    int   n;
    int   errs;
    int   first;
    logic pass;
    int   done_cyc;
  } run_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [SW+RW-1:0] ld_data = '0;
  logic start = 1'b0;
  logic [AW:0] num_vec = '0;

  logic [RW-1:0] dut_resp      [2];
  logic [SW-1:0] stim_out      [2];
  logic          stim_valid    [2];
  logic          busy          [2];
  logic          done          [2];
  logic          pass          [2];
  logic          mismatch      [2];
  logic [AW-1:0] vec_idx       [2];
  logic [15:0]   err_cnt       [2];
  logic [AW-1:0] first_err_idx [2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [SW+RW-1:0] mem_m [DEP];
  vec_t vq [2][$];
  run_t rq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Echo-style DUT model: response is a fixed mix of the stimulus bits.
  function automatic logic [RW-1:0] echo(input logic [SW-1:0] s);
    return s[9:0] ^ {5'b0, s[14:10]};
  endfunction

  assign dut_resp[0] = echo(stim_out[0]);
  assign dut_resp[1] = echo(stim_out[1]);

  vec_player #(.STIM_W(SW), .RESP_W(RW), .DEPTH(DEP), .ADDR_W(AW), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_vec(num_vec), .dut_resp(dut_resp[0]),
    .stim_out(stim_out[0]), .stim_valid(stim_valid[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .mismatch(mismatch[0]), .vec_idx(vec_idx[0]),
    .err_cnt(err_cnt[0]), .first_err_idx(first_err_idx[0])
  );

  vec_player #(.STIM_W(SW), .RESP_W(RW), .DEPTH(DEP), .ADDR_W(AW), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_vec(num_vec), .dut_resp(dut_resp[1]),
    .stim_out(stim_out[1]), .stim_valid(stim_valid[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .mismatch(mismatch[1]), .vec_idx(vec_idx[1]),
    .err_cnt(err_cnt[1]), .first_err_idx(first_err_idx[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  task automatic chk_zero(input int i);
    chk($sformatf("outputs_zero[%0d]", i),
        {20'b0, stim_out[i], stim_valid[i], busy[i], done[i], pass[i], mismatch[i],
         vec_idx[i], err_cnt[i], first_err_idx[i]}, 64'd0);
  endtask

  // Per-instance monitors.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int L = (gi == 0) ? 1 : 3;
    initial begin
      vec_t e;
      run_t r;
      int pulses;
      logic prev_done;
      logic aborted;
      pulses = 0;
      prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pulses = 0;
          prev_done = 1'b0;
          continue;
        end
        if (done[gi] && !prev_done) begin
          if (rq[gi].size() == 0) begin
            fail_evt($sformatf("done_rise[%0d]", gi));
          end else begin
            r = rq[gi].pop_front();
            chk($sformatf("err_cnt[%0d]", gi), 64'(err_cnt[gi]), 64'(r.errs));
            chk($sformatf("first_err_idx[%0d]", gi), 64'(first_err_idx[gi]), 64'(r.first));
            chk($sformatf("pass[%0d]", gi), 64'(pass[gi]), 64'(r.pass));
            chk($sformatf("valid_pulses[%0d]", gi), 64'(pulses), 64'(r.n));
            chk($sformatf("done_cycle[%0d]", gi), 64'(cyc), 64'(r.done_cyc));
          end
          pulses = 0;
        end
        prev_done = done[gi];
        if (stim_valid[gi]) begin
          pulses++;
          if (vq[gi].size() == 0) begin
            fail_evt($sformatf("stim_valid[%0d]", gi));
          end else begin
            e = vq[gi].pop_front();
            chk($sformatf("drive_idx[%0d]", gi), 64'(vec_idx[gi]), 64'(e.idx));
            chk($sformatf("drive_mismatch[%0d]", gi), 64'(mismatch[gi]), 64'd0);
            aborted = 1'b0;
            for (int j = 0; j < L; j++) begin
              @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              if (j < L - 1) begin
                chk($sformatf("wait_mismatch[%0d]", gi), 64'(mismatch[gi]), 64'd0);
              end
            end
            if (aborted) begin
              pulses = 0;
              prev_done = 1'b0;
            end else begin
              chk($sformatf("check_stim[%0d] v%0d", gi, e.idx), 64'(stim_out[gi]), 64'(e.stim));
              chk($sformatf("check_mismatch[%0d] v%0d", gi, e.idx), 64'(mismatch[gi]), 64'(e.bad));
              chk($sformatf("check_idx[%0d]", gi), 64'(vec_idx[gi]), 64'(e.idx));
              chk($sformatf("check_busy[%0d]", gi), 64'(busy[gi]), 64'd1);
            end
          end
        end
      end
    end
  end

  // Load one memory word; the model tracks it because callers only load when idle.
  task automatic load(input int a, input logic [SW-1:0] s, input logic [RW-1:0] r);
    ld_en = 1'b1;
    ld_addr = AW'(a);
    ld_data = {s, r};
    mem_m[a] = {s, r};
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue_start(input int nv, input logic do_ld, input int la,
                             input logic [SW-1:0] ls, input logic [RW-1:0] lr);
    int n;
    int sc;
    vec_t e;
    run_t r;
    start = 1'b1;
    num_vec = (AW + 1)'(nv);
    if (do_ld) begin
      ld_en = 1'b1;
      ld_addr = AW'(la);
      ld_data = {ls, lr};
      mem_m[la] = {ls, lr};
    end
    sc = cyc + 1;
    n = (nv > DEP) ? DEP : nv;
    if (n > 0) begin
      for (int i = 0; i < 2; i++) begin
        r.n = n;
        r.errs = 0;
        r.first = 0;
        for (int k = 0; k < n; k++) begin
          e.idx = k;
          e.stim = mem_m[k][SW+RW-1:RW];
          e.bad = (mem_m[k][RW-1:0] != echo(e.stim));
          if (e.bad) begin
            if (r.errs == 0) r.first = k;
            r.errs++;
          end
          vq[i].push_back(e);
        end
        r.pass = (r.errs == 0);
        r.done_cyc = sc + n * (((i == 0) ? 1 : 3) + 1);
        rq[i].push_back(r);
      end
    end
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    chk("busy_after_start[0]", 64'(busy[0]), 64'(n > 0));
    chk("busy_after_start[1]", 64'(busy[1]), 64'(n > 0));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (rq[0].size() == 0 && rq[1].size() == 0) break;
    end
    if (rq[0].size() != 0 || rq[1].size() != 0) begin
      fail_evt("done_timeout");
      for (int i = 0; i < 2; i++) begin
        vq[i].delete();
        rq[i].delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic load_all(input int corrupt_pct);
    logic [SW-1:0] s;
    logic [RW-1:0] r;
    for (int a = 0; a < DEP; a++) begin
      s = SW'($urandom);
      r = echo(s);
      if ($urandom_range(99) < corrupt_pct) r = r ^ RW'($urandom_range(1023, 1));
      load(a, s, r);
    end
  endtask

  initial begin
    logic [SW-1:0] s;
    // Reset with a start pulse buried inside it.
    @(negedge clk);
    start = 1'b1;
    num_vec = 5'd5;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);

    // Clean run over all vectors.
    load_all(0);
    issue_start(10, 1'b0, 0, '0, '0);
    wait_done();

    // Errors injected at vectors 3 and 7.
    s = mem_m[3][SW+RW-1:RW];
    load(3, s, echo(s) ^ 10'h040);
    s = mem_m[7][SW+RW-1:RW];
    load(7, s, echo(s) ^ 10'h201);
    issue_start(10, 1'b0, 0, '0, '0);
    wait_done();

    // Request beyond DEPTH is clamped.
    issue_start(15, 1'b0, 0, '0, '0);
    wait_done();

    // Zero-length request is ignored and done is held.
    issue_start(0, 1'b0, 0, '0, '0);
    chk("done_held[0]", 64'(done[0]), 64'd1);
    chk("done_held[1]", 64'(done[1]), 64'd1);

    // start and ld_en while busy are both ignored.
    load_all(30);
    issue_start(10, 1'b0, 0, '0, '0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    num_vec = 5'd3;
    ld_en = 1'b1;
    ld_addr = 4'd2;
    ld_data = {SW'($urandom), RW'($urandom)};
    @(negedge clk);
    start = 1'b0;
    ld_en = 1'b0;
    wait_done();

    // Reset during WAIT of vector 4 on the LAT=3 instance, then replay.
    issue_start(10, 1'b0, 0, '0, '0);
    repeat (17) @(negedge clk);
    chk("pre_reset_idx[1]", 64'(vec_idx[1]), 64'd4);
    chk("pre_reset_busy[1]", 64'(busy[1]), 64'd1);
    #1;
    for (int i = 0; i < 2; i++) begin
      vq[i].delete();
      rq[i].delete();
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    @(negedge clk);
    issue_start(10, 1'b0, 0, '0, '0);
    wait_done();

    // Load to address 0 in the same cycle as start.
    s = SW'($urandom);
    issue_start(4, 1'b1, 0, s, echo(s));
    wait_done();

    // Random runs.
    for (int t = 0; t < 3; t++) begin
      load_all(25);
      issue_start($urandom_range(15, 1), 1'b0, 0, '0, '0);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
